axi4_full_master: RTL and testbench
===================================

// Module: axi4_full_master
// PURPOSE
//  AXI4 burst initiator: turns a single-command request port into one INCR write or read burst.
//  Streams write beats from a local source and read beats to a local sink, then reports completion.
//  Pairs with the team's AXI4 full slave; used by test harnesses and DMA-style engines. One transaction at a time.
// PARAMETERS
//  G_ADDR_WIDTH  6   AXI byte-address width
//  G_DATA_WIDTH  32  data width; multiple of 8, <=1024
//  G_ID_WIDTH    2   AXI ID width
// PORTS (name dir width meaning)
//  clock      in   1     single clock; all logic posedge
//  reset      in   1     asynchronous, active-high reset
//  cmd_valid  in   1     command request
//  cmd_ready  out  1     master idle, command accepted when valid&&ready
//  cmd_write  in   1     1=write burst, 0=read burst
//  cmd_addr   in   G_ADDR_WIDTH  start byte address
//  cmd_len    in   8     beats-1 (AXI len encoding)
//  cmd_id     in   G_ID_WIDTH    transaction ID
//  wr_data/wr_valid/wr_ready  in/in/out  G_DATA_WIDTH/1/1  write-beat source stream
//  rd_data/rd_valid/rd_last   out  G_DATA_WIDTH/1/1  read-beat sink stream, no backpressure
//  done       out  1     1-cycle pulse at transaction end
//  done_resp  out  2     BRESP, or first non-OKAY RRESP, of finished transaction
//  err        out  1     sticky protocol error (see CONFIGURATION)
//  m_aw{valid,id,addr,len,size,burst}  out  1/ID/ADDR/8/3/2; m_awready in 1
//  m_w{valid,data,strb,last}  out  1/DATA/DATA/8/1; m_wready in 1
//  m_b{valid,id,resp}  in  1/ID/2; m_bready out 1
//  m_ar{valid,id,addr,len,size,burst}  out  1/ID/ADDR/8/3/2; m_arready in 1
//  m_r{valid,id,data,resp,last}  in  1/ID/DATA/2/1; m_rready out 1
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=IDLE; all m_*valid, m_bready, m_rready, done, err = 0;
//   done_resp=0; beat counter=0. cmd_ready=1 only in IDLE (0 while reset asserted).
//  FSM: IDLE -> AW|AR on cmd_valid&&cmd_ready (cmd_write selects); command fields registered.
//   AW: m_awvalid=1 held stable until m_awready; -> W.   AR: m_arvalid=1 until m_arready; -> R.
//   W: m_wvalid=wr_valid, wr_ready=m_wready, m_wdata=wr_data; beat on m_wvalid&&m_wready;
//      m_wlast=(cnt==len); beat with wlast -> B.   B: m_bready=1; on m_bvalid -> IDLE, done=1, done_resp=m_bresp.
//   R: m_rready=1; rd_valid=m_rvalid, rd_data=m_rdata, rd_last=(cnt==len); beat on m_rvalid;
//      beat at cnt==len -> IDLE, done=1. Completion by beat count, never by m_rlast.
//  Constants: awsize/arsize=$clog2(G_DATA_WIDTH/8); awburst/arburst=2'b01 (INCR); wstrb all ones.
//  Addresses passed unmodified; 4KB-boundary/alignment legality is the caller's responsibility.
//  Counter 8 bit, cleared on command accept; len=0 -> single beat with wlast/rd_last on first beat.
//  valid never depends on ready; AW/AR payload never changes while valid&&!ready.
//  cmd_valid while busy: ignored (cmd_ready=0). Write and read never overlap.
//  B/R arriving early (before last W / outside R) are not accepted (ready low).
//  Reset mid-burst: all valids drop immediately, FSM -> IDLE, no done pulse.
//  done and cmd_ready in the same cycle allowed: next command may be accepted the cycle after done.
// CONFIGURATION
//  AXI4_MASTER_RESP_CHECK_EN defined: err set (sticky until reset) on bid/rid != cmd_id,
//   BRESP/RRESP != 2'b00, or m_rlast mismatching (cnt==len); done_resp holds first non-OKAY RRESP.
//  Undefined: err tied 0, IDs/resp/rlast unchecked, done_resp=BRESP for writes, 2'b00 for reads.
// TESTING
//  Reset: assert reset mid-AW -> m_awvalid=0 same cycle, cmd_ready=1 after release, done never pulses.
//  Write len=3 addr=0x10 id=1, data 0xA0..0xA3 -> awaddr=0x10 awlen=3 awsize=2 awburst=1; 4 W beats,
//   wlast on 4th only; done=1 done_resp=0 after bvalid.
//  Read len=3 addr=0x10 id=1 -> rd_data 0xA0..0xA3, rd_last on 4th, done pulse, cmd_ready back to 1.
//  Stall: slave holds awready=0 5 cycles, wr_valid toggles -> awaddr stable, beat count exact, data order kept.
//  len=0 write then immediate read, cmd_valid held during write -> second cmd accepted only after done.
//  RESP_CHECK_EN: slave returns bid=2 for id=1 and rlast=0 on last beat -> err=1 sticky; undefined -> err=0.

Source files
------------

// File: rtl/axi4_full_master_if.sv
// AXI4 channel bundle between axi4_full_master and an AXI4 full slave.
// Ports (via modports):
//   master : drives AW/W/AR payload+valid, B/R ready; receives the rest.
//   slave  : mirror image of master.
// Parameters: ADDR_WIDTH, DATA_WIDTH, ID_WIDTH must match the master instance.
interface axi4_full_master_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // write address channel
    logic                  m_awvalid;
    logic                  m_awready;
    logic [ID_WIDTH-1:0]   m_awid;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic [2:0]            m_awsize;
    logic [1:0]            m_awburst;

    // write data channel
    logic                  m_wvalid;
    logic                  m_wready;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [STRB_WIDTH-1:0] m_wstrb;
    logic                  m_wlast;

    // write response channel
    logic                  m_bvalid;
    logic                  m_bready;
    logic [ID_WIDTH-1:0]   m_bid;
    logic [1:0]            m_bresp;

    // read address channel
    logic                  m_arvalid;
    logic                  m_arready;
    logic [ID_WIDTH-1:0]   m_arid;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;

    // read data channel
    logic                  m_rvalid;
    logic                  m_rready;
    logic [ID_WIDTH-1:0]   m_rid;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;

    modport master (
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_wready,
        input  m_bvalid, m_bid, m_bresp,
        output m_bready,
        output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
        input  m_arready,
        input  m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        output m_rready
    );

    modport slave (
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_wready,
        output m_bvalid, m_bid, m_bresp,
        input  m_bready,
        input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
        output m_arready,
        output m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        input  m_rready
    );
endinterface

// File: rtl/axi4_full_master.sv
// AXI4 burst initiator: one command in, one INCR write or read burst out,
// then a one-cycle done pulse with the transaction response.
// Ports:
//   clock, reset            single clock, asynchronous active-high reset
//   cmd_*                   valid/ready command port (write, addr, len, id)
//   wr_data/valid/ready     write-beat source stream (passed through to W)
//   rd_data/valid/last      read-beat sink stream (no backpressure)
//   done, done_resp         completion pulse and BRESP / first bad RRESP
//   err                     sticky protocol error flag
//   m_axi                   AXI4 master channels (axi4_full_master_if.master)
// Optional feature: define AXI4_MASTER_RESP_CHECK_EN to check B/R IDs,
// responses and RLAST and to report the first non-OKAY RRESP; otherwise err
// is tied low and reads report OKAY.
module axi4_full_master #(
    parameter int unsigned G_ADDR_WIDTH = 6,
    parameter int unsigned G_DATA_WIDTH = 32,
    parameter int unsigned G_ID_WIDTH   = 2
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [G_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [G_ID_WIDTH-1:0]   cmd_id,

    input  logic [G_DATA_WIDTH-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [G_DATA_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,

    output logic                    done,
    output logic [1:0]              done_resp,
    output logic                    err,

    axi4_full_master_if.master      m_axi
);
    localparam int unsigned STRB_WIDTH = G_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SIZE  = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_t;

    state_t                  state_q;
    logic [G_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]              len_q;
    logic [G_ID_WIDTH-1:0]   id_q;
    logic [7:0]              cnt_q;
    logic                    awvalid_q;
    logic                    arvalid_q;
    logic                    bready_q;
    logic                    rready_q;
`ifdef AXI4_MASTER_RESP_CHECK_EN
    logic [1:0]              rresp_q;
    logic [1:0]              rresp_next;
`endif

    logic last_beat;
    logic w_beat;
    logic r_beat;

    assign last_beat = (cnt_q == len_q);
    assign w_beat    = (state_q == S_W) && wr_valid && m_axi.m_wready;
    assign r_beat    = (state_q == S_R) && m_axi.m_rvalid;

    // Idle is the only state that takes a command; held low during reset.
    assign cmd_ready = (state_q == S_IDLE) && !reset;

    // Address channels carry the registered command, stable while valid.
    assign m_axi.m_awvalid = awvalid_q;
    assign m_axi.m_awid    = id_q;
    assign m_axi.m_awaddr  = addr_q;
    assign m_axi.m_awlen   = len_q;
    assign m_axi.m_awsize  = 3'(BEAT_SIZE);
    assign m_axi.m_awburst = 2'b01;

    assign m_axi.m_arvalid = arvalid_q;
    assign m_axi.m_arid    = id_q;
    assign m_axi.m_araddr  = addr_q;
    assign m_axi.m_arlen   = len_q;
    assign m_axi.m_arsize  = 3'(BEAT_SIZE);
    assign m_axi.m_arburst = 2'b01;

    // Write stream is a straight pass-through gated by the W state.
    assign m_axi.m_wvalid = (state_q == S_W) && wr_valid;
    assign m_axi.m_wdata  = wr_data;
    assign m_axi.m_wstrb  = {STRB_WIDTH{1'b1}};
    assign m_axi.m_wlast  = (state_q == S_W) && last_beat;
    assign wr_ready       = (state_q == S_W) && m_axi.m_wready;

    assign m_axi.m_bready = bready_q;
    assign m_axi.m_rready = rready_q;

    // Read stream: every R beat in the R state goes straight to the sink.
    assign rd_valid = r_beat;
    assign rd_data  = m_axi.m_rdata;
    assign rd_last  = (state_q == S_R) && last_beat;

`ifdef AXI4_MASTER_RESP_CHECK_EN
    // Keep the first non-OKAY RRESP of the burst, including the current beat.
    assign rresp_next = (rresp_q == 2'b00) ? m_axi.m_rresp : rresp_q;
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi.m_bid, m_axi.m_rid, m_axi.m_rresp, m_axi.m_rlast};
`endif

    // Transaction sequencer with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
            err       <= 1'b0;
`ifdef AXI4_MASTER_RESP_CHECK_EN
            rresp_q   <= 2'b00;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        id_q   <= cmd_id;
                        cnt_q  <= 8'd0;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                        rresp_q <= 2'b00;
`endif
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= S_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end

                S_AW: begin
                    if (m_axi.m_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_W;
                    end
                end

                S_W: begin
                    if (w_beat) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (last_beat) begin
                            bready_q <= 1'b1;
                            state_q  <= S_B;
                        end
                    end
                end

                S_B: begin
                    if (m_axi.m_bvalid) begin
                        bready_q  <= 1'b0;
                        done      <= 1'b1;
                        done_resp <= m_axi.m_bresp;
                        state_q   <= S_IDLE;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                        if ((m_axi.m_bid != id_q) || (m_axi.m_bresp != 2'b00))
                            err <= 1'b1;
`endif
                    end
                end

                S_AR: begin
                    if (m_axi.m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end

                S_R: begin
                    if (r_beat) begin
                        cnt_q <= cnt_q + 8'd1;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                        rresp_q <= rresp_next;
                        if ((m_axi.m_rid != id_q) || (m_axi.m_rresp != 2'b00) ||
                            (m_axi.m_rlast != last_beat))
                            err <= 1'b1;
`endif
                        // Completion is by beat count; RLAST is only checked.
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            done     <= 1'b1;
                            state_q  <= S_IDLE;
`ifdef AXI4_MASTER_RESP_CHECK_EN
                            done_resp <= rresp_next;
`else
                            done_resp <= 2'b00;
`endif
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_full_master.sv
// Directed testbench for axi4_full_master with a small AXI4 slave model and a
// scoreboard queue of expected W / read-stream data.
module tb_axi4_full_master;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

`ifdef AXI4_MASTER_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [IW-1:0] cmd_id;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          done;
    logic [1:0]    done_resp;
    logic          err;

    axi4_full_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi4_full_master #(
        .G_ADDR_WIDTH(AW),
        .G_DATA_WIDTH(DW),
        .G_ID_WIDTH  (IW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_id   (cmd_id),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .done     (done),
        .done_resp(done_resp),
        .err      (err),
        .m_axi    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- slave model ----------------
    int            aw_stall;
    logic [IW-1:0] bid_xor;
    logic          rlast_bad;

    logic [DW-1:0] mem [16];
    int            aw_wait;
    logic          aw_got;
    logic [AW-1:0] aw_addr_q;
    logic [IW-1:0] aw_id_q;
    logic [3:0]    wbeat;
    logic          bvalid_q;
    logic          ar_active;
    logic [AW-1:0] ar_addr_q;
    logic [7:0]    ar_len_q;
    logic [IW-1:0] ar_id_q;
    logic [7:0]    rbeat;

    assign bus.m_awready = !aw_got && (aw_wait >= aw_stall);
    assign bus.m_wready  = 1'b1;
    assign bus.m_bvalid  = bvalid_q;
    assign bus.m_bid     = aw_id_q ^ bid_xor;
    assign bus.m_bresp   = 2'b00;
    assign bus.m_arready = !ar_active;
    assign bus.m_rvalid  = ar_active;
    assign bus.m_rid     = ar_id_q;
    assign bus.m_rdata   = mem[4'(ar_addr_q[AW-1:2]) + rbeat[3:0]];
    assign bus.m_rresp   = 2'b00;
    assign bus.m_rlast   = (rbeat == ar_len_q) ^ rlast_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_wait   <= 0;
            aw_got    <= 1'b0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            wbeat     <= '0;
            bvalid_q  <= 1'b0;
            ar_active <= 1'b0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_id_q   <= '0;
            rbeat     <= '0;
        end else begin
            if (bus.m_awvalid && bus.m_awready) begin
                aw_wait   <= 0;
                aw_got    <= 1'b1;
                aw_addr_q <= bus.m_awaddr;
                aw_id_q   <= bus.m_awid;
                wbeat     <= '0;
            end else if (bus.m_awvalid) begin
                aw_wait <= aw_wait + 1;
            end
            if (bus.m_wvalid && bus.m_wready) begin
                mem[4'(aw_addr_q[AW-1:2]) + wbeat] <= bus.m_wdata;
                wbeat <= wbeat + 4'd1;
                if (bus.m_wlast) bvalid_q <= 1'b1;
            end
            if (bvalid_q && bus.m_bready) begin
                bvalid_q <= 1'b0;
                aw_got   <= 1'b0;
            end
            if (bus.m_arvalid && bus.m_arready) begin
                ar_active <= 1'b1;
                ar_addr_q <= bus.m_araddr;
                ar_len_q  <= bus.m_arlen;
                ar_id_q   <= bus.m_arid;
                rbeat     <= '0;
            end
            if (ar_active && bus.m_rready) begin
                rbeat <= rbeat + 8'd1;
                if (rbeat == ar_len_q) ar_active <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_beat"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(obs), 64'(e));
        end
    endtask

    // Issue a write burst and stream base+i data beats; toggle gaps wr_valid.
    task automatic run_write(input logic [AW-1:0] a, input logic [7:0] l,
                             input logic [IW-1:0] id, input logic [DW-1:0] base,
                             input bit toggle);
        int idx = 0;
        int sent = 0;
        int cyc = 0;
        bit adv = 0;
        bit fin = 0;
        exp_q.delete();
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l; cmd_id = id;
        wr_valid = 1'b0;
        #1 check("wr_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clock);
        cmd_valid = 1'b0;
        wr_data = base;
        exp_q.push_back(base);
        #1;
        check("awvalid", 64'(bus.m_awvalid), 64'(1));
        check("awaddr", 64'(bus.m_awaddr), 64'(a));
        check("awlen", 64'(bus.m_awlen), 64'(l));
        check("awsize", 64'(bus.m_awsize), 64'(2));
        check("awburst", 64'(bus.m_awburst), 64'(1));
        check("awid", 64'(bus.m_awid), 64'(id));
        while (!fin && cyc < 200) begin
            @(negedge clock);
            if (adv) begin
                idx++;
                adv = 0;
                if (idx <= int'(l)) begin
                    wr_data = base + DW'(idx);
                    exp_q.push_back(wr_data);
                end
            end
            wr_valid = (idx <= int'(l)) && (!toggle || (cyc % 2 == 0));
            #1;
            if (bus.m_awvalid) check("awaddr_stable", 64'(bus.m_awaddr), 64'(a));
            if (bus.m_wvalid && bus.m_wready) begin
                pop_check("wdata", bus.m_wdata);
                check("wlast", 64'(bus.m_wlast), 64'(sent == int'(l)));
                sent++;
                adv = 1;
            end
            if (done) begin
                fin = 1;
                check("wr_done_resp", 64'(done_resp), 64'(0));
                check("wr_done_cmd_ready", 64'(cmd_ready), 64'(1));
            end
            cyc++;
        end
        wr_valid = 1'b0;
        if (!fin) check("wr_done_timeout", 64'(0), 64'(1));
        check("wr_beat_count", 64'(sent), 64'(int'(l) + 1));
        check("wr_queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clock);
        #1 check("wr_done_single", 64'(done), 64'(0));
    endtask

    // Collect len+1 read beats against the queue and wait for done.
    task automatic collect_read(input logic [7:0] l);
        int got = 0;
        int cyc = 0;
        bit fin = 0;
        while (!fin && cyc < 200) begin
            @(negedge clock);
            #1;
            if (rd_valid) begin
                pop_check("rd_data", rd_data);
                check("rd_last", 64'(rd_last), 64'(got == int'(l)));
                got++;
            end
            if (done) begin
                fin = 1;
                check("rd_done_resp", 64'(done_resp), 64'(0));
                check("rd_done_cmd_ready", 64'(cmd_ready), 64'(1));
            end
            cyc++;
        end
        if (!fin) check("rd_done_timeout", 64'(0), 64'(1));
        check("rd_beat_count", 64'(got), 64'(int'(l) + 1));
        check("rd_queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clock);
        #1 check("rd_done_single", 64'(done), 64'(0));
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [IW-1:0] id, input logic [DW-1:0] base);
        exp_q.delete();
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; cmd_id = id;
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(base + DW'(i));
        #1 check("rd_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clock);
        cmd_valid = 1'b0;
        #1;
        check("arvalid", 64'(bus.m_arvalid), 64'(1));
        check("araddr", 64'(bus.m_araddr), 64'(a));
        check("arlen", 64'(bus.m_arlen), 64'(l));
        check("arsize", 64'(bus.m_arsize), 64'(2));
        check("arburst", 64'(bus.m_arburst), 64'(1));
        collect_read(l);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  cyc;
        bit  fin;
        int  wbeats;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data = '0; wr_valid = 1'b0;
        aw_stall = 0; bid_xor = '0; rlast_bad = 1'b0;

        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_awvalid", 64'(bus.m_awvalid), 64'(0));
        check("rst_arvalid", 64'(bus.m_arvalid), 64'(0));
        check("rst_bready", 64'(bus.m_bready), 64'(0));
        check("rst_rready", 64'(bus.m_rready), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_done_resp", 64'(done_resp), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1 check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Reset in the middle of an AW handshake.
        aw_stall = 20;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h08; cmd_len = 8'd1; cmd_id = 2'd0;
        @(negedge clock);
        cmd_valid = 1'b0;
        #1 check("midaw_awvalid", 64'(bus.m_awvalid), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("midaw_rst_awvalid", 64'(bus.m_awvalid), 64'(0));
        check("midaw_rst_cmd_ready", 64'(cmd_ready), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        aw_stall = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check("midaw_no_done", 64'(done), 64'(0));
            check("midaw_awvalid_low", 64'(bus.m_awvalid), 64'(0));
        end
        check("midaw_cmd_ready", 64'(cmd_ready), 64'(1));

        // Basic write then read-back.
        run_write(6'h10, 8'd3, 2'd1, 32'h0000_00A0, 1'b0);
        check("wr_err", 64'(err), 64'(0));
        run_read(6'h10, 8'd3, 2'd1, 32'h0000_00A0);
        check("rd_err", 64'(err), 64'(0));

        // AW stall with gapped write source, then read-back for order.
        aw_stall = 5;
        run_write(6'h30, 8'd3, 2'd2, 32'h0000_00B0, 1'b1);
        aw_stall = 0;
        run_read(6'h30, 8'd3, 2'd2, 32'h0000_00B0);

        // len=0 write with the following read command held valid throughout.
        exp_q.delete();
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h20; cmd_len = 8'd0; cmd_id = 2'd3;
        wr_valid = 1'b1; wr_data = 32'h5A5A_0001;
        exp_q.push_back(32'h5A5A_0001);
        #1 check("b2b_cmd_ready", 64'(cmd_ready), 64'(1));
        @(negedge clock);
        cmd_write = 1'b0;
        fin = 0; cyc = 0; wbeats = 0;
        while (!fin && cyc < 100) begin
            #1;
            if (bus.m_wvalid && bus.m_wready) begin
                pop_check("b2b_wdata", bus.m_wdata);
                check("b2b_wlast", 64'(bus.m_wlast), 64'(1));
                wbeats++;
            end
            if (done) fin = 1;
            else check("b2b_busy_cmd_ready", 64'(cmd_ready), 64'(0));
            if (!fin) @(negedge clock);
            cyc++;
        end
        if (!fin) check("b2b_done_timeout", 64'(0), 64'(1));
        check("b2b_wbeats", 64'(wbeats), 64'(1));
        check("b2b_done_cmd_ready", 64'(cmd_ready), 64'(1));
        wr_valid = 1'b0;
        exp_q.push_back(32'h5A5A_0001);
        @(negedge clock);
        cmd_valid = 1'b0;
        #1;
        check("b2b_arvalid", 64'(bus.m_arvalid), 64'(1));
        check("b2b_araddr", 64'(bus.m_araddr), 64'(6'h20));
        check("b2b_arlen", 64'(bus.m_arlen), 64'(0));
        collect_read(8'd0);

        // Wrong BID on a write, then a bad RLAST on a read.
        bid_xor = 2'b11;
        run_write(6'h10, 8'd3, 2'd1, 32'h0000_00C0, 1'b0);
        bid_xor = 2'b00;
        check("bid_err", 64'(err), 64'(EXP_ERR));
        rlast_bad = 1'b1;
        run_read(6'h10, 8'd3, 2'd1, 32'h0000_00C0);
        rlast_bad = 1'b0;
        check("rlast_err_sticky", 64'(err), 64'(EXP_ERR));
        repeat (3) @(negedge clock);
        #1 check("err_still_sticky", 64'(err), 64'(EXP_ERR));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
